// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the 5-stage pipeline.
// It owns HI/LO. It accepts mult/multu/div/divu (and madd/maddu when MD_MADD_EN
// is defined) from E. The result is computed when the op is issued and held in
// staging registers. It is committed to HI/LO after a fixed number of busy cycles.
//
// Optional feature macro: MD_MADD_EN (madd/maddu accumulate into HI/LO).
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   start, md_op       E-stage issue strobe and op (000 mult .. 101 maddu)
//   src_a, src_b       E-stage operands (rs, rt)
//   hilo_wr, hilo_sel  mthi/mtlo strobe, 1=HI 0=LO; wr_data is the write value
//   d_is_md            D-stage instruction touches the md unit / HI / LO
//   busy, md_stall     op in flight; stall request to the hazard unit
//   done               one-cycle pulse after HI/LO commit
//   hi, lo             architectural HI/LO registers
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_wr,
  input  logic        hilo_sel,
  input  logic [31:0] wr_data,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] stg_q, stg_d;
  logic        skip_q, skip_d;   // divide by zero: commit leaves HI/LO alone
  logic        done_q, done_d;
`ifdef MD_MADD_EN
  logic        acc_q, acc_d;     // commit adds staging onto live HI/LO
`endif

  // Arithmetic on the issue operands. The divisor is forced to 1 on a zero
  // divide. This keeps the divider result defined. That result is discarded anyway.
  logic        b_zero;
  logic [31:0] div_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign b_zero = (src_b == 32'd0);
  assign div_b  = b_zero ? 32'd1 : src_b;
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign q_s    = $signed(src_a) / $signed(div_b);
  assign r_s    = $signed(src_a) % $signed(div_b);
  assign q_u    = src_a / div_b;
  assign r_u    = src_a % div_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stg_d   = stg_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
`ifdef MD_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // start has priority: a simultaneous mthi/mtlo is dropped.
          // A reserved op is also a no-op in this case.
          state_d = RUN;
          skip_d  = 1'b0;
`ifdef MD_MADD_EN
          acc_d   = 1'b0;
`endif
          case (md_op)
            3'b000: begin stg_d = prod_s; cnt_d = 4'(MULT_CYCLES); end
            3'b001: begin stg_d = prod_u; cnt_d = 4'(MULT_CYCLES); end
            3'b010: begin stg_d = {r_s, q_s}; skip_d = b_zero; cnt_d = 4'(DIV_CYCLES); end
            3'b011: begin stg_d = {r_u, q_u}; skip_d = b_zero; cnt_d = 4'(DIV_CYCLES); end
`ifdef MD_MADD_EN
            3'b100: begin stg_d = prod_s; acc_d = 1'b1; cnt_d = 4'(MULT_CYCLES); end
            3'b101: begin stg_d = prod_u; acc_d = 1'b1; cnt_d = 4'(MULT_CYCLES); end
`endif
            default: state_d = IDLE;
          endcase
        end else if (hilo_wr) begin
          if (hilo_sel) hi_d = wr_data;
          else          lo_d = wr_data;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!skip_q) begin
`ifdef MD_MADD_EN
            {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + stg_q) : stg_q;
`else
            {hi_d, lo_d} = stg_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      stg_q   <= 64'd0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MD_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stg_q   <= stg_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
`ifdef MD_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = d_is_md & (start | busy);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
